// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream in preamble, SFD, zero pad and FCS,
// then holds the inter-frame gap. Byte-wide at 1G, two nibbles per byte in 10/100 mode.
module gmii_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_DATA       = 60,
    parameter int IFG_BYTES      = 12
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       speed_10_100,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_ERR, ST_DRAIN, ST_IFG
    } state_t;

    localparam logic [7:0]  LP_PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [10:0] LP_MIN      = 11'(MIN_DATA);

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] fn_txd(input logic [7:0] b, input logic nib);
        return nib ? {4'h0, b[3:0]} : b;
    endfunction

    state_t      r_state;
    logic        r_nib;
    logic        r_ph;
    logic [7:0]  r_cnt;
    logic [10:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_byte;
    logic        r_eof;
    logic [7:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_frame_done;
    logic        r_underrun;

    logic        w_slot_end;
    logic        w_take;
    logic        w_start;
    logic        w_pad_more;
    logic        w_phased;
    logic [10:0] w_byte_cnt_inc;
    logic [31:0] w_crc_inv;
    logic [1:0]  w_fcs_idx;
    logic [7:0]  w_fcs_nxt;

    // State and outputs describe the cycle currently on the wire; a slot ends on its last cycle.
    assign w_slot_end     = !r_nib || r_ph;
    assign w_take         = ((r_state == ST_SFD) || (r_state == ST_DATA && !r_eof)) && w_slot_end;
    assign w_start        = s_valid && ((r_state == ST_IDLE) ||
                            (r_state == ST_IFG && w_slot_end && r_cnt == LP_IFG_LAST));
    assign w_pad_more     = r_byte_cnt < LP_MIN;
    assign w_phased       = (r_state != ST_IDLE) && (r_state != ST_DRAIN);
    assign w_byte_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_crc_inv      = ~r_crc;
    assign w_fcs_idx      = r_cnt[1:0] + 2'd1;
    assign w_fcs_nxt      = w_crc_inv[{w_fcs_idx, 3'b000} +: 8];

    assign s_ready    = w_take || (r_state == ST_DRAIN);
    assign gmii_txd   = r_txd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_nib        <= 1'b0;
            r_ph         <= 1'b0;
            r_cnt        <= 8'd0;
            r_byte_cnt   <= 11'd0;
            r_crc        <= 32'hFFFFFFFF;
            r_byte       <= 8'h00;
            r_eof        <= 1'b0;
            r_txd        <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            if (w_start) begin
                // Speed is sampled only here, so a mid-frame change waits for the next frame.
                r_state    <= ST_PRE;
                r_nib      <= speed_10_100;
                r_ph       <= 1'b0;
                r_cnt      <= 8'd0;
                r_crc      <= 32'hFFFFFFFF;
                r_byte_cnt <= 11'd0;
                r_eof      <= 1'b0;
                r_byte     <= 8'h55;
                r_txd      <= fn_txd(8'h55, speed_10_100);
                r_tx_en    <= 1'b1;
                r_tx_er    <= 1'b0;
            end else if (w_phased && r_nib && !r_ph) begin
                r_ph  <= 1'b1;
                r_txd <= {4'h0, r_byte[7:4]};
            end else begin
                r_ph <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_txd   <= 8'h00;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                    end
                    ST_PRE: begin
                        if (r_cnt == LP_PRE_LAST) begin
                            r_state <= ST_SFD;
                            r_byte  <= 8'hD5;
                            r_txd   <= fn_txd(8'hD5, r_nib);
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_byte <= 8'h55;
                            r_txd  <= fn_txd(8'h55, r_nib);
                        end
                    end
                    ST_SFD, ST_DATA, ST_PAD: begin
                        if (w_take && s_valid) begin
                            r_state    <= ST_DATA;
                            r_byte     <= s_data;
                            r_txd      <= fn_txd(s_data, r_nib);
                            r_crc      <= crc_next(r_crc, s_data);
                            r_byte_cnt <= w_byte_cnt_inc;
                            r_eof      <= s_last;
                        end else if (w_take) begin
                            r_state    <= ST_ERR;
                            r_byte     <= 8'h00;
                            r_txd      <= 8'h00;
                            r_tx_er    <= 1'b1;
                            r_underrun <= 1'b1;
                        end else if (w_pad_more) begin
                            r_state    <= ST_PAD;
                            r_byte     <= 8'h00;
                            r_txd      <= 8'h00;
                            r_crc      <= crc_next(r_crc, 8'h00);
                            r_byte_cnt <= w_byte_cnt_inc;
                        end else begin
                            r_state <= ST_FCS;
                            r_cnt   <= 8'd0;
                            r_byte  <= w_crc_inv[7:0];
                            r_txd   <= fn_txd(w_crc_inv[7:0], r_nib);
                        end
                    end
                    ST_FCS: begin
                        if (r_cnt == 8'd3) begin
                            r_state      <= ST_IFG;
                            r_cnt        <= 8'd0;
                            r_byte       <= 8'h00;
                            r_txd        <= 8'h00;
                            r_tx_en      <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_byte <= w_fcs_nxt;
                            r_txd  <= fn_txd(w_fcs_nxt, r_nib);
                        end
                    end
                    ST_ERR: begin
                        r_state <= ST_DRAIN;
                        r_byte  <= 8'h00;
                        r_txd   <= 8'h00;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                    end
                    ST_DRAIN: begin
                        if (s_valid && s_last) begin
                            r_state <= ST_IFG;
                            r_cnt   <= 8'd0;
                        end
                    end
                    ST_IFG: begin
                        if (r_cnt == LP_IFG_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                        r_txd   <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
